// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for a register file: each port has a 1-entry skid
// buffer, buffered writes drain through a single round-robin write port.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  input  logic [4:0]  p0_rd,
  input  logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_rd,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_w,
  output logic [31:0] rf_d,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic        hazard_a,
  output logic        hazard_b,
  output logic        busy
);

  logic        buf0_valid_q, buf0_valid_d;
  logic [4:0]  buf0_rd_q, buf0_rd_d;
  logic [31:0] buf0_data_q, buf0_data_d;
  logic        buf1_valid_q, buf1_valid_d;
  logic [4:0]  buf1_rd_q, buf1_rd_d;
  logic [31:0] buf1_data_q, buf1_data_d;
  // 1 when port 1 was granted most recently, so port 0 wins the next tie.
  logic        last1_q, last1_d;

  logic v0, v1, grant0, grant1, acc0, acc1;

  // Buffers are masked while reset is held so outputs read idle in that cycle.
  assign v0 = buf0_valid_q && rst_n;
  assign v1 = buf1_valid_q && rst_n;

  assign grant0 = v0 && (!v1 || last1_q);
  assign grant1 = v1 && (!v0 || !last1_q);

  // Valid/ready: a request transfers on a posedge where valid and ready are
  // both high; ready is combinational so a port can refill while it drains.
  assign p0_ready = !v0 || grant0;
  assign p1_ready = !v1 || grant1;
  assign acc0     = p0_valid && p0_ready;
  assign acc1     = p1_valid && p1_ready;

  assign rf_wen = (grant0 && (buf0_rd_q != 5'd0)) || (grant1 && (buf1_rd_q != 5'd0));
  assign rf_w   = grant0 ? buf0_rd_q   : (grant1 ? buf1_rd_q   : 5'd0);
  assign rf_d   = grant0 ? buf0_data_q : (grant1 ? buf1_data_q : 32'd0);

  assign hazard_a = (ra != 5'd0) && ((v0 && buf0_rd_q == ra) || (v1 && buf1_rd_q == ra));
  assign hazard_b = (rb != 5'd0) && ((v0 && buf0_rd_q == rb) || (v1 && buf1_rd_q == rb));
  assign busy     = v0 || v1;

  always_comb begin
    buf0_valid_d = buf0_valid_q;
    buf0_rd_d    = buf0_rd_q;
    buf0_data_d  = buf0_data_q;
    buf1_valid_d = buf1_valid_q;
    buf1_rd_d    = buf1_rd_q;
    buf1_data_d  = buf1_data_q;
    last1_d      = last1_q;
    if (acc0) begin
      buf0_valid_d = 1'b1;
      buf0_rd_d    = p0_rd;
      buf0_data_d  = p0_data;
    end else if (grant0) begin
      buf0_valid_d = 1'b0;
    end
    if (acc1) begin
      buf1_valid_d = 1'b1;
      buf1_rd_d    = p1_rd;
      buf1_data_d  = p1_data;
    end else if (grant1) begin
      buf1_valid_d = 1'b0;
    end
    if (grant0) begin
      last1_d = 1'b0;
    end else if (grant1) begin
      last1_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0_valid_q <= 1'b0;
      buf1_valid_q <= 1'b0;
      last1_q      <= 1'b1;
    end else begin
      buf0_valid_q <= buf0_valid_d;
      buf1_valid_q <= buf1_valid_d;
      last1_q      <= last1_d;
    end
  end

  // Payload registers only change on accept, so they need no reset.
  always_ff @(posedge clk) begin
    buf0_rd_q   <= buf0_rd_d;
    buf0_data_q <= buf0_data_d;
    buf1_rd_q   <= buf1_rd_d;
    buf1_data_q <= buf1_data_d;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued as stimulus
// is issued and a negedge monitor checks every enabled register-file write.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p1_valid;
  logic [4:0]  p0_rd, p1_rd;
  logic [31:0] p0_data, p1_data;
  logic        p0_ready, p1_ready;
  logic        rf_wen;
  logic [4:0]  rf_w;
  logic [31:0] rf_d;
  logic [4:0]  ra, rb;
  logic        hazard_a, hazard_b, busy;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data), .p1_ready(p1_ready),
    .rf_wen(rf_wen), .rf_w(rf_w), .rf_d(rf_d),
    .ra(ra), .rb(rb), .hazard_a(hazard_a), .hazard_b(hazard_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Monitor: every enabled write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got w=%0d d=%0h expected no write", rf_w, rf_d);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_w, rf_d} !== e) begin
          failures++;
          $display("FAIL write_order: got w=%0d d=%0h expected w=%0d d=%0h",
                   rf_w, rf_d, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no end of stimulus expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    p0_valid = 1'b0; p0_rd = 5'd0; p0_data = 32'd0;
    p1_valid = 1'b0; p1_rd = 5'd0; p1_data = 32'd0;
    ra = 5'd0; rb = 5'd0;
    tick; tick;
    chk("rst_wen", rf_wen, 0);
    chk("rst_ready", {p0_ready, p1_ready}, 2'b11);
    chk("rst_busy", busy, 0);
    chk("rst_hazard", {hazard_a, hazard_b}, 2'b00);
    rst_n = 1'b1;
    tick;

    // Contention right after reset: port 0 first.
    p0_valid = 1; p0_rd = 5'd3; p0_data = 32'h11;
    p1_valid = 1; p1_rd = 5'd4; p1_data = 32'h22;
    push(5'd3, 32'h11); push(5'd4, 32'h22);
    tick;
    p0_valid = 0; p1_valid = 0;
    chk("cont1_first", rf_w, 5'd3);
    tick;
    chk("cont1_second", rf_w, 5'd4);
    tick;
    chk("cont1_idle", busy, 0);

    // Port 0 granted alone, so the next tie goes to port 1.
    p0_valid = 1; p0_rd = 5'd9; p0_data = 32'h99;
    push(5'd9, 32'h99);
    tick;
    p0_valid = 0;
    tick;
    p0_valid = 1; p0_rd = 5'd3; p0_data = 32'h55;
    p1_valid = 1; p1_rd = 5'd4; p1_data = 32'h66;
    push(5'd4, 32'h66); push(5'd3, 32'h55);
    tick;
    p0_valid = 0; p1_valid = 0;
    chk("cont2_first", rf_w, 5'd4);
    tick;
    chk("cont2_second", rf_w, 5'd3);
    tick;

    // Single uncontended write.
    p0_valid = 1; p0_rd = 5'd5; p0_data = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    tick;
    p0_valid = 0;
    chk("single_write", {rf_wen, rf_w, rf_d}, {1'b1, 5'd5, 32'hDEADBEEF});
    tick;
    chk("single_after", {rf_wen, busy}, 2'b00);

    // x0 destination: consumed without a write enable.
    p1_valid = 1; p1_rd = 5'd0; p1_data = 32'hFFFFFFFF;
    tick;
    p1_valid = 0;
    chk("x0_grant", {rf_wen, busy, p1_ready}, 3'b011);
    tick;
    chk("x0_after", {rf_wen, busy, p1_ready}, 3'b001);

    // Hazard on a buffered write, including its commit cycle.
    p1_valid = 1; p1_rd = 5'd7; p1_data = 32'h77;
    push(5'd7, 32'h77);
    tick;
    p1_valid = 0;
    ra = 5'd7; rb = 5'd0;
    #1;
    chk("hazard_set", {hazard_a, hazard_b}, 2'b10);
    tick;
    chk("hazard_clear", {hazard_a, hazard_b}, 2'b00);
    ra = 5'd0;

    // Back-to-back on port 0.
    for (int i = 0; i < 8; i++) begin
      p0_valid = 1; p0_rd = 5'(i + 1); p0_data = 32'h100 + 32'(i);
      push(5'(i + 1), 32'h100 + 32'(i));
      chk("b2b_ready", p0_ready, 1);
      if (i > 0) chk("b2b_write", {rf_wen, rf_w}, {1'b1, 5'(i)});
      tick;
    end
    p0_valid = 0;
    chk("b2b_last", {rf_wen, rf_w}, {1'b1, 5'd8});
    tick;
    chk("b2b_idle", busy, 0);

    // Reset with both buffers loaded; a request held during reset is dropped.
    p0_valid = 1; p0_rd = 5'd10; p0_data = 32'hA;
    p1_valid = 1; p1_rd = 5'd11; p1_data = 32'hB;
    tick;
    rst_n = 0; p1_valid = 0;
    p0_rd = 5'd14; p0_data = 32'hE;
    ra = 5'd10; rb = 5'd11;
    #1;
    chk("midrst_during", {rf_wen, busy, p0_ready, p1_ready, hazard_a, hazard_b}, 6'b001100);
    tick;
    rst_n = 1; p0_valid = 0;
    chk("midrst_after", {rf_wen, busy, p0_ready, p1_ready}, 4'b0011);
    tick;
    chk("midrst_noaccept", busy, 0);
    ra = 5'd0; rb = 5'd0;

    p0_valid = 1; p0_rd = 5'd12; p0_data = 32'hC;
    p1_valid = 1; p1_rd = 5'd13; p1_data = 32'hD;
    push(5'd12, 32'hC); push(5'd13, 32'hD);
    tick;
    p0_valid = 0; p1_valid = 0;
    chk("postrst_first", rf_w, 5'd12);
    tick;
    chk("postrst_second", rf_w, 5'd13);
    tick; tick;

    chk("queue_drained", 37'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
